inference_result_tx: RTL and testbench
======================================

// Module: inference_result_tx
// PURPOSE
//  Result-side counterpart of the inference core: snapshots predicted_digit and the ten
//  class scores when inference signals done, then streams them to the host link as a
//  framed byte sequence over a valid/ready handshake. Sits between inference and the
//  host transmitter (UART/FIFO), so results leave the FPGA without host polling.
// PARAMETERS
//  SYNC_BYTE    8'hA5  first byte of every frame
//  SEND_SCORES  1      1: frame = sync, digit, 40 score bytes, checksum (43 B); 0: sync, digit, checksum (3 B)
// PORTS
//  clk              in   1   system clock
//  rst              in   1   asynchronous, active-high reset
//  done             in   1   inference done level; a 0->1 transition triggers a frame
//  predicted_digit  in   4   argmax class, 0..9
//  class_score_0..9 in   32  signed logits, one port per class
//  tx_data          out  8   current frame byte
//  tx_valid         out  1   tx_data is valid
//  tx_ready         in   1   downstream accepts byte when tx_valid&&tx_ready
//  busy             out  1   frame in progress (state != IDLE)
//  frame_done       out  1   one-cycle pulse after the last byte handshake
//  overrun          out  1   sticky: a done edge arrived while busy
//  clr_overrun      in   1   synchronous clear of overrun
// BEHAVIOUR
//  - Reset (async): state IDLE, done_q=0, tx_valid=0, tx_data=0, busy=0, frame_done=0,
//    overrun=0, byte index=0, checksum=0, snapshot regs=0. Reset mid-frame aborts at once.
//  - done_edge = done & ~done_q (combinational); done_q <= done every cycle.
//  - IDLE: on done_edge, capture digit and all 10 scores into shadow regs, index<=0,
//    checksum<=0, go SEND. tx_valid=1 with SYNC_BYTE from the next cycle (1-cycle latency).
//  - SEND: tx_data/tx_valid held stable until handshake; index advances only on
//    tx_valid&&tx_ready. tx_valid never drops mid-frame; tx_ready low stalls indefinitely.
//  - Byte order: 0 = SYNC_BYTE; 1 = {4'h0, digit}; 2..41 = scores class 0..9, each
//    little-endian (byte 2 = score0[7:0]); last = checksum. Inputs ignored after snapshot.
//  - Checksum: running XOR of bytes 1..N-2 (everything except sync and checksum itself),
//    updated on each accepted byte.
//  - After the last byte is accepted: state IDLE, tx_valid=0 same edge, frame_done=1 for
//    exactly the following cycle.
//  - done_edge while not IDLE (incl. the cycle the last byte is accepted): overrun<=1,
//    frame and snapshot unaffected, no frame queued. clr_overrun with a same-cycle set:
//    set wins. done held high does not retrigger; a new frame needs done low then high.
//  - No tx_valid-without-busy; busy==(state==SEND).
// STRUCTURE
//  - States IDLE/SEND as a 1-bit enum; frame length, SYNC default and byte-index width
//    (6 bits) in the shared lenet package alongside NUM_CLASSES=10.
//  - Single module; byte select is a mux over a 320-bit packed snapshot indexed by
//    (index-2). No sub-module required.
// TESTING
//  - digit=3, score3=32'h12345678, others 0, tx_ready=1 -> 43 bytes: A5 03, 12x00,
//    78 56 34 12, 24x00, checksum 0B; frame_done pulse 1 cycle after byte 42.
//  - score0=-1 (32'hFFFFFFFF), digit=0 -> bytes 2..5 = FF FF FF FF, checksum 00.
//  - tx_ready toggled randomly per cycle -> identical byte sequence; tx_data stable
//    while tx_valid&&!tx_ready.
//  - Second done edge at byte 10 -> overrun=1, frame completes unchanged, no second
//    frame; clr_overrun -> overrun=0 next cycle.
//  - SEND_SCORES=0, digit=7 -> frame A5 07 07, busy for exactly 3 handshakes.
//  - rst pulsed at byte 20 -> tx_valid=0, busy=0 immediately; next done edge sends a
//    complete fresh frame starting with A5.

Source files
------------

// File: rtl/inference_result_tx_pkg.sv
// Shared constants for the inference result path: class count, frame geometry, FSM encodings.
package inference_result_tx_pkg;

  localparam int unsigned NUM_CLASSES     = 10;
  localparam int unsigned SCORE_W         = 32;
  localparam int unsigned SNAP_W          = NUM_CLASSES * SCORE_W;
  localparam int unsigned SCORE_BYTES     = SNAP_W / 8;
  localparam int unsigned IDX_W           = 6;
  localparam int unsigned FRAME_LEN_FULL  = SCORE_BYTES + 3;
  localparam int unsigned FRAME_LEN_SHORT = 3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Index of the checksum byte, i.e. the final byte of a frame.
  function automatic logic [IDX_W-1:0] last_index(input bit send_scores);
    return send_scores ? IDX_W'(FRAME_LEN_FULL - 1) : IDX_W'(FRAME_LEN_SHORT - 1);
  endfunction

endpackage

// File: rtl/inference_result_tx.sv
// Snapshots the inference result on a done rising edge and streams it as a framed,
// XOR-checksummed byte sequence over a valid/ready link.
module inference_result_tx
  import inference_result_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter bit         SEND_SCORES = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [3:0]  predicted_digit,
  input  logic [31:0] class_score_0,
  input  logic [31:0] class_score_1,
  input  logic [31:0] class_score_2,
  input  logic [31:0] class_score_3,
  input  logic [31:0] class_score_4,
  input  logic [31:0] class_score_5,
  input  logic [31:0] class_score_6,
  input  logic [31:0] class_score_7,
  input  logic [31:0] class_score_8,
  input  logic [31:0] class_score_9,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  input  logic        clr_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = last_index(SEND_SCORES);

  logic [0:0]        state, state_d;
  logic              done_q;
  logic              done_edge;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [7:0]        csum, csum_d;
  logic [7:0]        tx_data_d;
  logic              tx_valid_d, busy_d, frame_done_d, overrun_d;
  logic              capture;
  logic [3:0]        digit_q;
  logic [SNAP_W-1:0] snap;

  assign done_edge = done & ~done_q;

  // Byte at frame position i; scores are little-endian, class 0 first.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] i,
                                         input logic [7:0]       cs,
                                         input logic [3:0]       dg,
                                         input logic [SNAP_W-1:0] sv);
    logic [7:0]       b;
    logic [IDX_W-1:0] sel;
    b   = 8'h00;
    sel = i - IDX_W'(2);
    if (i == '0) begin
      b = SYNC_BYTE;
    end else if (i == LAST_IDX) begin
      b = cs;
    end else if (i == IDX_W'(1)) begin
      b = {4'h0, dg};
    end else begin
      for (int unsigned k = 0; k < SCORE_BYTES; k++) begin
        if (sel == IDX_W'(k)) b = sv[k*8 +: 8];
      end
    end
    return b;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    csum_d       = csum;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    frame_done_d = 1'b0;
    overrun_d    = overrun;
    capture      = 1'b0;

    // A set in the same cycle as a clear wins.
    if (clr_overrun) overrun_d = 1'b0;
    if (done_edge && (state != ST_IDLE)) overrun_d = 1'b1;

    if (state == ST_IDLE) begin
      if (done_edge) begin
        capture    = 1'b1;
        idx_d      = '0;
        csum_d     = 8'h00;
        state_d    = ST_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = SYNC_BYTE;
      end
    end else begin
      if (tx_valid && tx_ready) begin
        if (idx == LAST_IDX) begin
          state_d      = ST_IDLE;
          idx_d        = '0;
          tx_valid_d   = 1'b0;
          tx_data_d    = 8'h00;
          frame_done_d = 1'b1;
        end else begin
          // Sync byte is excluded from the checksum.
          csum_d    = (idx == '0) ? csum : (csum ^ tx_data);
          idx_d     = idx + IDX_W'(1);
          tx_data_d = byte_at(idx_d, csum_d, digit_q, snap);
        end
      end
    end

    busy_d = (state_d == ST_SEND);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      done_q     <= 1'b0;
      idx        <= '0;
      csum       <= 8'h00;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      done_q     <= done;
      idx        <= idx_d;
      csum       <= csum_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

  // Result snapshot, frozen for the life of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'h0;
      snap    <= '0;
    end else if (capture) begin
      digit_q <= predicted_digit;
      snap    <= {class_score_9, class_score_8, class_score_7, class_score_6, class_score_5,
                  class_score_4, class_score_3, class_score_2, class_score_1, class_score_0};
    end
  end

endmodule

// File: tb/tb_inference_result_tx.sv
// Directed bench for inference_result_tx: full and short frames, stalls, overrun, reset.
module tb_inference_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        done, done2;
  logic [3:0]  digit;
  logic [31:0] sc [10];
  logic        tx_ready, tx_ready2, clr_overrun;
  logic [7:0]  tx_data, tx_data2;
  logic        tx_valid, busy, frame_done, overrun;
  logic        tx_valid2, busy2, frame_done2, overrun2;

  int asserts = 0;
  int fails   = 0;

  logic [7:0] expb  [64];
  int         exp_len;
  logic [7:0] got_b [64];
  int         got_n;
  bit         stable_ok, fd_ok;

  always #5 clk = ~clk;

  inference_result_tx #(.SYNC_BYTE(8'hA5), .SEND_SCORES(1'b1)) dut (
    .clk(clk), .rst(rst), .done(done), .predicted_digit(digit),
    .class_score_0(sc[0]), .class_score_1(sc[1]), .class_score_2(sc[2]), .class_score_3(sc[3]),
    .class_score_4(sc[4]), .class_score_5(sc[5]), .class_score_6(sc[6]), .class_score_7(sc[7]),
    .class_score_8(sc[8]), .class_score_9(sc[9]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  inference_result_tx #(.SYNC_BYTE(8'hA5), .SEND_SCORES(1'b0)) dut_short (
    .clk(clk), .rst(rst), .done(done2), .predicted_digit(digit),
    .class_score_0(sc[0]), .class_score_1(sc[1]), .class_score_2(sc[2]), .class_score_3(sc[3]),
    .class_score_4(sc[4]), .class_score_5(sc[5]), .class_score_6(sc[6]), .class_score_7(sc[7]),
    .class_score_8(sc[8]), .class_score_9(sc[9]),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2),
    .frame_done(frame_done2), .overrun(overrun2), .clr_overrun(clr_overrun)
  );

  // Reference frame from the current digit/score inputs.
  task automatic build_expected(input logic [3:0] d, input bit full);
    logic [7:0]  x;
    logic [31:0] s;
    expb[0] = 8'hA5;
    expb[1] = {4'h0, d};
    x       = {4'h0, d};
    exp_len = 2;
    if (full) begin
      for (int c = 0; c < 10; c++) begin
        s = sc[c];
        for (int b = 0; b < 4; b++) begin
          expb[exp_len] = s[8*b +: 8];
          x = x ^ s[8*b +: 8];
          exp_len++;
        end
      end
    end
    expb[exp_len] = x;
    exp_len++;
  endtask

  task automatic set_scores(input logic [31:0] base);
    for (int c = 0; c < 10; c++) sc[c] = base + 32'(c * 32'h01010101);
  endtask

  // Rising edge on done; returns one cycle later with the frame started.
  task automatic trigger();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  // Receives n bytes from the full-frame instance; optional random stalls and a
  // done edge (with input scribbling) once edge_at bytes have been taken.
  task automatic collect(input int n, input bit rnd, input int edge_at);
    bit         hold, fired;
    logic [7:0] hold_data;
    got_n = 0; stable_ok = 1'b1; hold = 1'b0; fired = 1'b0; hold_data = 8'h00;
    for (int cyc = 0; cyc < 3000 && got_n < n; cyc++) begin
      if (tx_valid !== 1'b1) stable_ok = 1'b0;
      if (hold && (tx_data !== hold_data)) stable_ok = 1'b0;
      if (edge_at >= 0) begin
        if (!fired && got_n == edge_at) begin
          done  = 1'b1;
          fired = 1'b1;
          digit = 4'hF;
          for (int c = 0; c < 10; c++) sc[c] = 32'hDEADBEEF;
        end else begin
          done = 1'b0;
        end
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        got_b[got_n] = tx_data;
        got_n++;
        hold = 1'b0;
      end else begin
        hold      = tx_valid;
        hold_data = tx_data;
      end
      @(posedge clk); #1;
    end
    if (edge_at >= 0) done = 1'b0;
    tx_ready = 1'b1;
    fd_ok = (frame_done === 1'b1) && (tx_valid === 1'b0) && (busy === 1'b0);
    @(posedge clk); #1;
    fd_ok = fd_ok && (frame_done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; done2 = 1'b0; digit = 4'h0; tx_ready = 1'b0; tx_ready2 = 1'b0;
    clr_overrun = 1'b0;
    for (int c = 0; c < 10; c++) sc[c] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    asserts++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    asserts++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    asserts++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    asserts++; if ({tx_valid, busy, tx_valid2, busy2} !== 4'b0000) begin
      fails++; $display("FAIL idle_after_reset got %b want 0000", {tx_valid, busy, tx_valid2, busy2});
    end
  endtask

  task automatic test_basic();
    digit = 4'd3;
    for (int c = 0; c < 10; c++) sc[c] = 32'h0;
    sc[3] = 32'h12345678;
    for (int i = 0; i < 64; i++) expb[i] = 8'h00;
    expb[0] = 8'hA5; expb[1] = 8'h03;
    expb[14] = 8'h78; expb[15] = 8'h56; expb[16] = 8'h34; expb[17] = 8'h12;
    expb[42] = 8'h0B;
    exp_len = 43;
    trigger();
    asserts++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_first_byte got v=%b d=%h b=%b want v=1 d=a5 b=1", tx_valid, tx_data, busy);
    end
    collect(43, 1'b0, -1);
    asserts++; if (got_n !== 43) begin fails++; $display("FAIL basic_count got %0d want 43", got_n); end
    for (int i = 0; i < 43; i++) begin
      asserts++; if (got_b[i] !== expb[i]) begin fails++; $display("FAIL basic_byte%0d got %h want %h", i, got_b[i], expb[i]); end
    end
    asserts++; if (!fd_ok) begin fails++; $display("FAIL basic_frame_done got %b want 1", fd_ok); end
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL basic_overrun got %b want 0", overrun); end
  endtask

  task automatic test_negative_score();
    digit = 4'd0;
    for (int c = 0; c < 10; c++) sc[c] = 32'h0;
    sc[0] = 32'hFFFFFFFF;
    build_expected(digit, 1'b1);
    trigger();
    collect(43, 1'b0, -1);
    asserts++; if (got_n !== 43) begin fails++; $display("FAIL neg_count got %0d want 43", got_n); end
    for (int i = 0; i < 43; i++) begin
      asserts++; if (got_b[i] !== expb[i]) begin fails++; $display("FAIL neg_byte%0d got %h want %h", i, got_b[i], expb[i]); end
    end
    asserts++; if (got_b[42] !== 8'h00) begin fails++; $display("FAIL neg_checksum got %h want 00", got_b[42]); end
  endtask

  task automatic test_random_ready();
    digit = 4'd9;
    set_scores(32'h80F1_2233);
    build_expected(digit, 1'b1);
    trigger();
    collect(43, 1'b1, -1);
    asserts++; if (got_n !== 43) begin fails++; $display("FAIL rnd_count got %0d want 43", got_n); end
    for (int i = 0; i < 43; i++) begin
      asserts++; if (got_b[i] !== expb[i]) begin fails++; $display("FAIL rnd_byte%0d got %h want %h", i, got_b[i], expb[i]); end
    end
    asserts++; if (!stable_ok) begin fails++; $display("FAIL rnd_stable got %b want 1", stable_ok); end
    asserts++; if (!fd_ok) begin fails++; $display("FAIL rnd_frame_done got %b want 1", fd_ok); end
  endtask

  task automatic test_overrun();
    bit saw_valid;
    digit = 4'd5;
    set_scores(32'h0A0B_0C0D);
    build_expected(digit, 1'b1);
    trigger();
    collect(43, 1'b0, 10);
    asserts++; if (got_n !== 43) begin fails++; $display("FAIL ovr_count got %0d want 43", got_n); end
    for (int i = 0; i < 43; i++) begin
      asserts++; if (got_b[i] !== expb[i]) begin fails++; $display("FAIL ovr_byte%0d got %h want %h", i, got_b[i], expb[i]); end
    end
    asserts++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b want 1", overrun); end
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    asserts++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL ovr_no_second_frame got %b want 0", saw_valid); end
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_done_held();
    bit saw_valid;
    digit = 4'd1;
    set_scores(32'h7700_0011);
    build_expected(digit, 1'b1);
    done = 1'b1;
    @(posedge clk); #1;
    collect(43, 1'b0, -1);
    asserts++; if (got_n !== 43) begin fails++; $display("FAIL held_count got %0d want 43", got_n); end
    asserts++; if (got_b[42] !== expb[42]) begin fails++; $display("FAIL held_checksum got %h want %h", got_b[42], expb[42]); end
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid !== 1'b0) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    asserts++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL held_no_retrigger got %b want 0", saw_valid); end
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL held_overrun got %b want 0", overrun); end
    done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_short_frame();
    logic [7:0] sb [8];
    int         sn, bc;
    sn = 0; bc = 0;
    digit = 4'd7;
    tx_ready2 = 1'b1;
    done2 = 1'b1;
    @(posedge clk); #1;
    done2 = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (busy2 === 1'b1) bc++;
      if (tx_valid2 && tx_ready2 && sn < 8) begin sb[sn] = tx_data2; sn++; end
      @(posedge clk); #1;
    end
    asserts++; if (sn !== 3) begin fails++; $display("FAIL short_count got %0d want 3", sn); end
    asserts++; if ({sb[0], sb[1], sb[2]} !== 24'hA50707) begin
      fails++; $display("FAIL short_bytes got %h%h%h want a50707", sb[0], sb[1], sb[2]);
    end
    asserts++; if (bc !== 3) begin fails++; $display("FAIL short_busy_cycles got %0d want 3", bc); end
  endtask

  task automatic test_reset_mid_frame();
    digit = 4'd2;
    set_scores(32'h5566_7788);
    build_expected(digit, 1'b1);
    trigger();
    collect(20, 1'b0, -1);
    rst = 1'b1;
    #1;
    asserts++; if ({tx_valid, busy} !== 2'b00 || tx_data !== 8'h00) begin
      fails++; $display("FAIL rst_mid got v=%b b=%b d=%h want 0 0 00", tx_valid, busy, tx_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    trigger();
    asserts++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL rst_fresh_sync got %h want a5", tx_data); end
    collect(43, 1'b0, -1);
    asserts++; if (got_n !== 43) begin fails++; $display("FAIL rst_fresh_count got %0d want 43", got_n); end
    for (int i = 0; i < 43; i++) begin
      asserts++; if (got_b[i] !== expb[i]) begin fails++; $display("FAIL rst_fresh_byte%0d got %h want %h", i, got_b[i], expb[i]); end
    end
    asserts++; if (!fd_ok) begin fails++; $display("FAIL rst_fresh_frame_done got %b want 1", fd_ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_score();
    test_random_ready();
    test_overrun();
    test_done_held();
    test_short_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
